// File: rtl/fsm_core_pkg.sv
// Shared state encoding for the consecutive-ones detector.
package fsm_core_pkg;

  typedef enum logic [1:0] {
    S0 = 2'b00,  // last bit 0, or just out of reset
    S1 = 2'b01,  // exactly one trailing 1
    S2 = 2'b10   // two or more trailing 1s
  } state_t;

  function automatic logic is_detect(input state_t s);
    return (s == S2);
  endfunction

endpackage

// File: rtl/fsm_core.sv
// Moore detector: Out is high while two or more consecutive 1s have been seen on In.
module fsm_core
  import fsm_core_pkg::*;
(
  input  logic clock,
  input  logic reset_b,
  input  logic In,
  output logic Out
);

  state_t state, state_nxt;

  always_ff @(posedge clock) begin
    if (!reset_b) state <= S0;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = S0;
    case (state)
      S0:      state_nxt = In ? S1 : S0;
      S1:      state_nxt = In ? S2 : S0;
      S2:      state_nxt = In ? S2 : S0;
      // 2'b11 is unreachable; recover to idle
      default: state_nxt = S0;
    endcase
  end

  // Decoded from registered state only, so In never reaches Out combinationally.
  assign Out = is_detect(state);

endmodule

// File: tb/tb_fsm_core.sv
// Table-driven and randomized checks of fsm_core against a trailing-ones count model.
module tb_fsm_core;

  logic clock = 1'b0;
  logic reset_b = 1'b1;
  logic In = 1'b0;
  logic Out;

  int n_checks = 0;
  int n_fail = 0;

  fsm_core dut (
    .clock   (clock),
    .reset_b (reset_b),
    .In      (In),
    .Out     (Out)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit rst_b;
    bit in;
    bit exp_out;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: Out=%b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // drive at negedge, sample 1 time unit after the next rising edge
  task automatic step(input bit r, input bit i);
    @(negedge clock);
    reset_b = r;
    In = i;
    @(posedge clock);
    #1;
  endtask

  task automatic add(input bit r, input bit i, input bit e);
    vec_t v;
    v.rst_b = r; v.in = i; v.exp_out = e;
    vecs.push_back(v);
  endtask

  initial begin
    int ones;
    bit r, i;
    string nm;

    // reset from undefined state
    add(0, 1, 0);
    // 0,1,1,0,0 -> 0,0,1,0,0
    add(1, 0, 0); add(1, 1, 0); add(1, 1, 1); add(1, 0, 0); add(1, 0, 0);
    // run of five ones, then a zero
    add(1, 1, 0); add(1, 1, 1); add(1, 1, 1); add(1, 1, 1); add(1, 1, 1);
    add(1, 0, 0);
    // alternating never detects
    add(1, 1, 0); add(1, 0, 0); add(1, 1, 0); add(1, 0, 0);
    // reset mid-run from S2; first bit after release follows a 0
    add(1, 1, 0); add(1, 1, 1); add(0, 1, 0); add(1, 1, 0); add(1, 1, 1);
    // reset from S1
    add(1, 0, 0); add(1, 1, 0); add(0, 1, 0); add(1, 1, 0); add(1, 1, 1);
    // reset with In=0 from S2, then restart
    add(0, 0, 0); add(1, 0, 0); add(1, 1, 0); add(1, 1, 1);

    foreach (vecs[k]) begin
      step(vecs[k].rst_b, vecs[k].in);
      nm = $sformatf("vec%0d", k);
      check(nm, Out, vecs[k].exp_out);
    end

    // reset pulse entirely between edges has no effect (currently in S2)
    @(negedge clock);
    In = 1'b1;
    reset_b = 1'b0;
    #2;
    reset_b = 1'b1;
    #1;
    check("glitch_between_edges", Out, 1'b1);
    @(posedge clock);
    #1;
    check("glitch_after_edge", Out, 1'b1);

    // In toggling mid-cycle must not disturb Out
    step(1, 0);
    step(1, 1);
    check("s1_out", Out, 1'b0);
    In = 1'b0;
    #1;
    In = 1'b1;
    #1;
    check("no_comb_path_s1", Out, 1'b0);
    @(posedge clock);
    #1;
    check("s1_to_s2", Out, 1'b1);
    In = 1'b0;
    #2;
    check("no_comb_path_s2", Out, 1'b1);

    // randomized phase: model tracks count of trailing ones since reset/zero
    step(0, 0);
    ones = 0;
    check("rand_reset", Out, 1'b0);
    for (int n = 0; n < 400; n++) begin
      r = ($urandom_range(0, 9) != 0);
      i = ($urandom_range(0, 2) != 0);
      step(r, i);
      if (!r)      ones = 0;
      else if (i)  ones = (ones < 2) ? ones + 1 : 2;
      else         ones = 0;
      nm = $sformatf("rand%0d", n);
      check(nm, Out, ones >= 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fsm_core.md
FSM_CORE -- requirements
Module: fsm_core

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-low reset named reset_b; the clock port is named clock.
REQ-002 Parameter: none; state encoding fixed by shared package constants (see Structure).
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset_b  input  1  synchronous active-low reset, sampled on rising clock.
REQ-005 In  input  1  serial data bit, sampled on rising clock.
REQ-006 Out  output  1  detect flag, Moore output decoded from current state only.

Function
REQ-007 The block SHALL be a Moore detector of two or more consecutive 1s on In.
REQ-008 States SHALL be S0 (last bit 0 or post-reset), S1 (exactly one trailing 1), S2 (two or more trailing 1s).
REQ-009 Transitions on rising clock with reset_b=1: S0: In=1->S1, In=0->S0; S1: In=1->S2, In=0->S0; S2: In=1->S2, In=0->S0.
REQ-010 Out SHALL be 1 only in S2 and 0 in S0 and S1.
REQ-011 Out SHALL change only after a rising clock edge; In SHALL have no combinational path to Out.
REQ-012 Latency: second consecutive 1 sampled at edge N -> Out=1 from edge N until the edge that samples a 0.
REQ-013 Overlap: a run of k>=2 ones SHALL hold Out=1 for k-1 cycles.
REQ-014 Unused/illegal state encodings SHALL transition to S0 on the next clock edge with Out=0.
REQ-015 Before the first reset, state is undefined; no requirement applies.

Reset
REQ-016 reset_b=0 at a rising clock SHALL force S0 (Out=0) regardless of In or current state.
REQ-017 Reset SHALL take priority over all transitions, including mid-run (e.g. in S2).
REQ-018 Assertion or deassertion of reset_b between clock edges SHALL have no effect until the next rising edge.
REQ-019 After reset_b returns to 1, the first sampled In SHALL be treated as following a 0.

Structure
REQ-020 A shared package fsm_core_pkg SHALL hold the 2-bit state type and constants S0=2'b00, S1=2'b01, S2=2'b10.
REQ-021 The RTL SHALL be split into a state register, a next-state combinational block, and an output decode; no sub-module is required.

Verification
REQ-022 Reset: reset_b=0 for one edge from any state -> Out=0, state S0.
REQ-023 Sequence In=0,1,1,0,0 over five edges after reset -> Out=0,0,1,0,0.
REQ-024 Long run In=1 x5 -> Out=0,1,1,1,1; then In=0 -> Out=0.
REQ-025 Alternating In=1,0,1,0 -> Out stays 0.
REQ-026 Reset mid-run: In=1,1 (Out=1), then reset_b=0 with In=1 -> Out=0; release with In=1 -> Out=0, next In=1 -> Out=1.
REQ-027 Reset toggled low then high between edges (no rising edge while low) -> state and Out unchanged.
